lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
Load/store unit sitting between the memory-stage pipeline and a word-wide data bus. It aligns store data and byte enables onto bus lanes. It right-aligns load data and emits a size mask for the load-extend stage that follows. Misaligned accesses that straddle a word boundary are split into two bus transactions.

Parameters:
ADDR_W, 32, byte-address width; the bus is always 32-bit data, 4 byte lanes.

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_req  in  1  access request from pipeline; sampled only in IDLE
i_we  in  1  1 = store, 0 = load
i_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
i_addr  in  ADDR_W  byte address
i_wdata  in  32  store data, right-aligned
o_busy  out  1  high whenever FSM is not IDLE; pipeline stalls
o_done  out  1  one-cycle completion pulse, loads and stores
o_rdata  out  32  right-aligned load data; bits above access size are zero
o_mask  out  4  0001 byte, 0011 half, 1111 word; feeds the extend stage
o_bus_req  out  1  bus request
o_bus_we  out  1  bus write
o_bus_addr  out  ADDR_W  word-aligned bus address, low 2 bits zero
o_bus_be  out  4  byte-lane enables
o_bus_wdata  out  32  lane-rotated store data
i_bus_ack  in  1  transaction-complete strobe
i_bus_rdata  in  32  read data, valid in the ack cycle

Behaviour:
- Reset is asynchronous. All outputs go to 0 and the FSM goes to IDLE, including mid-transaction. o_bus_req drops in the same instant. No o_done is issued for the aborted access.
- States: IDLE, ACC0, ACC1, DONE.
- IDLE, i_req=1: register we, size, addr, wdata, and off = addr[1:0]. Compute smask = 0001/0011/1111 from size and be_full[7:0] = smask << off.
  - Go to ACC0.
  - split = (be_full[7:4] != 0).
- ACC0:
  - o_bus_req=1, o_bus_addr = {addr[ADDR_W-1:2], 2'b00}, o_bus_be = be_full[3:0].
  - o_bus_wdata = wdata rotated left by 8*off.
  - On i_bus_ack: capture the enabled lanes. Go to ACC1 if split, else DONE.
- ACC1:
  - o_bus_addr = previous word address + 4, modulo 2^ADDR_W, so 0xFFFFFFFC wraps to 0x0.
  - o_bus_be = be_full[7:4]; same rotated wdata.
  - On i_bus_ack, go to DONE.
- Handshake: address, be, we and wdata are held stable while o_bus_req=1 and i_bus_ack=0. A transaction completes in any cycle where req and ack are both high; zero-wait ack is legal. While req=0, i_bus_ack is ignored. o_bus_req deasserts for at least the DONE cycle between accesses.
- DONE: o_done=1 for one cycle, then return to IDLE. o_busy = (state != IDLE).
- i_req while busy is ignored; the pipeline must hold it.
- Load assembly:
  - Result byte k comes from global lane off+k.
  - Lanes 0–3 come from the ACC0 data; lanes 4–7 come from ACC1 lanes 0–3.
  - Result bytes beyond the size are zero.
- o_rdata and o_mask update in the DONE cycle and hold until the next load completes. Stores do not alter o_rdata or o_mask.
- Latency:
  - Aligned access with zero-wait ack: accept in cycle 0, ACC0 in cycle 1, o_done in cycle 2.
  - Split access adds one bus transaction.
  - Each wait cycle adds one.
- Byte accesses never split. Half splits only at off=3. Word splits at off=1..3.

Decomposition:
- Package lsu_pkg: size enum (SZ_B, SZ_H, SZ_W), FSM state enum, function size_to_mask(size) returning 4-bit mask.
- Sub-module lsu_lane_align, combinational:
  - Generates be_full and rotated wdata from size, offset and data.
  - Extracts right-aligned load data from two 32-bit words plus offset and size.

Test Plan:
1. Word load at 0x100, bus acks in the same cycle with 0xDEADBEEF -> single transaction at 0x100 with be 1111; o_done in cycle 2; o_rdata 0xDEADBEEF; o_mask 1111.
2. Byte load at 0x103, bus rdata 0x80AABBCC -> be 1000; o_rdata 0x00000080; o_mask 0001.
3. Half store at 0x102 with wdata 0x1234ABCD -> one transaction at 0x100, be 1100, o_bus_wdata[31:16] = 0xABCD, we=1; o_done pulses; o_rdata unchanged.
4. Word load at 0x101 -> first transaction 0x100 be 1110 returning 0x44332211, second 0x104 be 0001 returning 0x88776655; o_rdata 0x55443322; o_mask 1111.
5. Word store at 0xFFFFFFFE with 3 wait cycles per ack, wdata 0xA1B2C3D4 -> 0xFFFFFFFC be 1100 then 0x00000000 be 0011, wdata 0xC3D4A1B2 held stable across waits; o_busy high throughout; a new i_req during busy is ignored.
6. Assert i_rst_n=0 while in ACC1 waiting for ack -> o_bus_req and o_busy drop immediately, no o_done. After release, an aligned byte load at 0x0 completes normally.

Source files
------------

// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared types and helpers for the load/store unit: access sizes, FSM states,
// and mask expansion functions.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ACC0 = 2'b01,
        ACC1 = 2'b10,
        DONE = 2'b11
    } state_e;

    // Encoding 2'b11 falls through to the word mask.
    function automatic logic [3:0] size_to_mask(input logic [1:0] size);
        if (size == SZ_B) return 4'b0001;
        if (size == SZ_H) return 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] be_to_bits(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Pipeline-side and bus-side signals of the LSU. The LSU takes the slave
// modport; the pipeline/bus environment takes the master modport.
interface lsu_mem_ctrl_if #(parameter int ADDR_W = 32);
    logic              i_req;
    logic              i_we;
    logic [1:0]        i_size;
    logic [ADDR_W-1:0] i_addr;
    logic [31:0]       i_wdata;
    logic              o_busy;
    logic              o_done;
    logic [31:0]       o_rdata;
    logic [3:0]        o_mask;
    logic              o_bus_req;
    logic              o_bus_we;
    logic [ADDR_W-1:0] o_bus_addr;
    logic [3:0]        o_bus_be;
    logic [31:0]       o_bus_wdata;
    logic              i_bus_ack;
    logic [31:0]       i_bus_rdata;

    modport master (
        output i_req, i_we, i_size, i_addr, i_wdata, i_bus_ack, i_bus_rdata,
        input  o_busy, o_done, o_rdata, o_mask,
        input  o_bus_req, o_bus_we, o_bus_addr, o_bus_be, o_bus_wdata
    );

    modport slave (
        input  i_req, i_we, i_size, i_addr, i_wdata, i_bus_ack, i_bus_rdata,
        output o_busy, o_done, o_rdata, o_mask,
        output o_bus_req, o_bus_we, o_bus_addr, o_bus_be, o_bus_wdata
    );
endinterface

// File: rtl/lsu_mem_ctrl_lane_align.sv
// Combinational lane steering: byte enables and rotated store data for the
// bus, and right-aligned, size-masked load data from up to two bus words.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rword0,
    input  logic [31:0] rword1,
    output logic [7:0]  be_full,
    output logic [31:0] wdata_rot,
    output logic [31:0] rdata
);
    logic [3:0] smask;
    logic [4:0] sh;
    logic [5:0] sh_inv;

    always_comb begin
        smask   = size_to_mask(size);
        sh      = {off, 3'b000};
        sh_inv  = 6'd32 - {1'b0, sh};
        be_full = {4'b0000, smask} << off;
        // A shift by 32 yields zero, so off=0 needs no special case.
        wdata_rot = (wdata << sh) | (wdata >> sh_inv);
        rdata     = ((rword0 >> sh) | (rword1 << sh_inv)) & be_to_bits(smask);
    end
endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: splits word-straddling accesses into two bus transactions,
// rotates store data onto lanes and right-aligns load data.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    lsu_mem_ctrl_if.slave lsu
);
    state_e            state_q, state_d;
    logic              we_q;
    logic [1:0]        size_q;
    logic [1:0]        off_q;
    logic [ADDR_W-3:0] word_q;
    logic [ADDR_W-3:0] word_nxt;
    logic [31:0]       wdata_q;
    logic [31:0]       rword0_q;
    logic [31:0]       rdata_q;
    logic [3:0]        mask_q;

    logic [7:0]  be_full;
    logic [31:0] wdata_rot;
    logic [31:0] rword0, rword1;
    logic [31:0] rdata_asm;
    logic        split;
    logic        acc0_ack, acc1_ack, load_fin;

    assign word_nxt = word_q + (ADDR_W-2)'(1);
    assign split    = |be_full[7:4];
    assign acc0_ack = (state_q == ACC0) && lsu.i_bus_ack;
    assign acc1_ack = (state_q == ACC1) && lsu.i_bus_ack;
    assign load_fin = !we_q && ((acc0_ack && !split) || acc1_ack);

    // Feed the ack-cycle bus data straight in so o_rdata is valid in DONE.
    assign rword0 = (state_q == ACC0) ? (lsu.i_bus_rdata & be_to_bits(be_full[3:0])) : rword0_q;
    assign rword1 = (state_q == ACC1) ? (lsu.i_bus_rdata & be_to_bits(be_full[7:4])) : 32'h0;

    lsu_lane_align u_align (
        .size      (size_q),
        .off       (off_q),
        .wdata     (wdata_q),
        .rword0    (rword0),
        .rword1    (rword1),
        .be_full   (be_full),
        .wdata_rot (wdata_rot),
        .rdata     (rdata_asm)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            size_q   <= 2'b00;
            off_q    <= 2'b00;
            word_q   <= '0;
            wdata_q  <= '0;
            rword0_q <= '0;
            rdata_q  <= '0;
            mask_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && lsu.i_req) begin
                we_q    <= lsu.i_we;
                size_q  <= lsu.i_size;
                off_q   <= lsu.i_addr[1:0];
                word_q  <= lsu.i_addr[ADDR_W-1:2];
                wdata_q <= lsu.i_wdata;
            end
            if (acc0_ack) rword0_q <= rword0;
            if (load_fin) begin
                rdata_q <= rdata_asm;
                mask_q  <= size_to_mask(size_q);
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        lsu.o_bus_req   = 1'b0;
        lsu.o_bus_we    = 1'b0;
        lsu.o_bus_addr  = '0;
        lsu.o_bus_be    = 4'b0000;
        lsu.o_bus_wdata = 32'h0;
        lsu.o_done      = 1'b0;
        case (state_q)
            IDLE: if (lsu.i_req) state_d = ACC0;
            ACC0: begin
                lsu.o_bus_req   = 1'b1;
                lsu.o_bus_we    = we_q;
                lsu.o_bus_addr  = {word_q, 2'b00};
                lsu.o_bus_be    = be_full[3:0];
                lsu.o_bus_wdata = wdata_rot;
                if (lsu.i_bus_ack) state_d = split ? ACC1 : DONE;
            end
            ACC1: begin
                lsu.o_bus_req   = 1'b1;
                lsu.o_bus_we    = we_q;
                lsu.o_bus_addr  = {word_nxt, 2'b00};
                lsu.o_bus_be    = be_full[7:4];
                lsu.o_bus_wdata = wdata_rot;
                if (lsu.i_bus_ack) state_d = DONE;
            end
            DONE: begin
                lsu.o_done = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign lsu.o_busy  = (state_q != IDLE);
    assign lsu.o_rdata = rdata_q;
    assign lsu.o_mask  = mask_q;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: aligned/misaligned loads and stores,
// wait states, address wrap and mid-access reset.
module tb_lsu_mem_ctrl;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    lsu_mem_ctrl_if #(.ADDR_W(32)) bus_if ();

    lsu_mem_ctrl #(.ADDR_W(32)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .lsu     (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Start an access; returns at the negedge where the FSM sits in ACC0.
    task automatic issue(input logic we, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata);
        bus_if.i_req   = 1'b1;
        bus_if.i_we    = we;
        bus_if.i_size  = size;
        bus_if.i_addr  = addr;
        bus_if.i_wdata = wdata;
        @(negedge clk);
        bus_if.i_req   = 1'b0;
    endtask

    task automatic bus_phase(input string tag, input logic [31:0] eaddr, input logic [3:0] ebe,
                             input logic ewe, input logic [31:0] ewd, input int waits,
                             input logic [31:0] rd);
        chk({tag, "_req"}, 32'(bus_if.o_bus_req), 32'h1);
        chk({tag, "_busy"}, 32'(bus_if.o_busy), 32'h1);
        chk({tag, "_addr"}, bus_if.o_bus_addr, eaddr);
        chk({tag, "_be"}, 32'(bus_if.o_bus_be), 32'(ebe));
        chk({tag, "_we"}, 32'(bus_if.o_bus_we), 32'(ewe));
        chk({tag, "_wdata"}, bus_if.o_bus_wdata, ewd);
        for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            chk({tag, "_hold_req"}, 32'(bus_if.o_bus_req), 32'h1);
            chk({tag, "_hold_busy"}, 32'(bus_if.o_busy), 32'h1);
            chk({tag, "_hold_addr"}, bus_if.o_bus_addr, eaddr);
            chk({tag, "_hold_be"}, 32'(bus_if.o_bus_be), 32'(ebe));
            chk({tag, "_hold_we"}, 32'(bus_if.o_bus_we), 32'(ewe));
            chk({tag, "_hold_wdata"}, bus_if.o_bus_wdata, ewd);
        end
        bus_if.i_bus_ack   = 1'b1;
        bus_if.i_bus_rdata = rd;
        @(negedge clk);
        bus_if.i_bus_ack   = 1'b0;
        bus_if.i_bus_rdata = 32'h0;
    endtask

    // Called at the DONE negedge; checks the pulse and the return to IDLE.
    task automatic chk_done(input string tag, input logic [31:0] erd, input logic [3:0] emask);
        bus_if.i_req = 1'b0;
        chk({tag, "_done"}, 32'(bus_if.o_done), 32'h1);
        chk({tag, "_done_busreq"}, 32'(bus_if.o_bus_req), 32'h0);
        chk({tag, "_rdata"}, bus_if.o_rdata, erd);
        chk({tag, "_mask"}, 32'(bus_if.o_mask), 32'(emask));
        @(negedge clk);
        chk({tag, "_done_clr"}, 32'(bus_if.o_done), 32'h0);
        chk({tag, "_idle"}, 32'(bus_if.o_busy), 32'h0);
        chk({tag, "_idle_req"}, 32'(bus_if.o_bus_req), 32'h0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus_if.i_req       = 1'b0;
        bus_if.i_we        = 1'b0;
        bus_if.i_size      = 2'b00;
        bus_if.i_addr      = 32'h0;
        bus_if.i_wdata     = 32'h0;
        bus_if.i_bus_ack   = 1'b0;
        bus_if.i_bus_rdata = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus_if.o_busy), 32'h0);
        chk("rst_done", 32'(bus_if.o_done), 32'h0);
        chk("rst_busreq", 32'(bus_if.o_bus_req), 32'h0);
        chk("rst_rdata", bus_if.o_rdata, 32'h0);
        chk("rst_mask", 32'(bus_if.o_mask), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: aligned word load, zero-wait ack
        issue(1'b0, 2'b10, 32'h100, 32'h0);
        bus_phase("t1", 32'h100, 4'b1111, 1'b0, 32'h0, 0, 32'hDEADBEEF);
        chk_done("t1", 32'hDEADBEEF, 4'b1111);

        // 2: byte load from top lane
        issue(1'b0, 2'b00, 32'h103, 32'h0);
        bus_phase("t2", 32'h100, 4'b1000, 1'b0, 32'h0, 0, 32'h80AABBCC);
        chk_done("t2", 32'h00000080, 4'b0001);

        // 3: half store at offset 2 leaves load result untouched
        issue(1'b1, 2'b01, 32'h102, 32'h1234ABCD);
        bus_phase("t3", 32'h100, 4'b1100, 1'b1, 32'hABCD1234, 0, 32'hFFFFFFFF);
        chk_done("t3", 32'h00000080, 4'b0001);

        // 4: misaligned word load split over two words
        issue(1'b0, 2'b10, 32'h101, 32'h0);
        bus_phase("t4a", 32'h100, 4'b1110, 1'b0, 32'h0, 0, 32'h44332211);
        bus_phase("t4b", 32'h104, 4'b0001, 1'b0, 32'h0, 0, 32'h88776655);
        chk_done("t4", 32'h55443322, 4'b1111);

        // 5: split store wrapping the address space, 3 waits, ignored request
        issue(1'b1, 2'b10, 32'hFFFFFFFE, 32'hA1B2C3D4);
        bus_if.i_req  = 1'b1;
        bus_if.i_we   = 1'b0;
        bus_if.i_addr = 32'h40;
        bus_phase("t5a", 32'hFFFFFFFC, 4'b1100, 1'b1, 32'hC3D4A1B2, 3, 32'h0);
        bus_phase("t5b", 32'h00000000, 4'b0011, 1'b1, 32'hC3D4A1B2, 3, 32'h0);
        chk_done("t5", 32'h55443322, 4'b1111);

        // 6: reset while waiting in the second transaction
        issue(1'b0, 2'b10, 32'h1FE, 32'h0);
        bus_phase("t6a", 32'h1FC, 4'b1100, 1'b0, 32'h0, 0, 32'h12345678);
        chk("t6_acc1_addr", bus_if.o_bus_addr, 32'h200);
        chk("t6_acc1_be", 32'(bus_if.o_bus_be), 32'h3);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_busreq", 32'(bus_if.o_bus_req), 32'h0);
        chk("t6_rst_busy", 32'(bus_if.o_busy), 32'h0);
        chk("t6_rst_done", 32'(bus_if.o_done), 32'h0);
        chk("t6_rst_rdata", bus_if.o_rdata, 32'h0);
        chk("t6_rst_mask", 32'(bus_if.o_mask), 32'h0);
        @(negedge clk);
        chk("t6_rst_done2", 32'(bus_if.o_done), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_post_done", 32'(bus_if.o_done), 32'h0);
        chk("t6_post_busy", 32'(bus_if.o_busy), 32'h0);
        issue(1'b0, 2'b00, 32'h0, 32'h0);
        bus_phase("t6b", 32'h0, 4'b0001, 1'b0, 32'h0, 0, 32'h123456AB);
        chk_done("t6", 32'h000000AB, 4'b0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
